// File: rtl/riscv_core_fetch_queue.sv
// riscv_core_fetch_queue: pairs in-order imem responses with their request PCs and feeds decode
module riscv_core_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_rdy,
  input  logic        imemreq_fire,
  input  logic [31:0] imemreq_pc,
  input  logic        imemresp_val,
  input  logic [31:0] imemresp_msg_data,
  input  logic        squash,
  output logic        inst_val_Fhl,
  input  logic        inst_rdy_Fhl,
  output logic [31:0] inst_Fhl,
  output logic [31:0] pc_Fhl
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d, fill_ptr_q, fill_ptr_d, deq_ptr_q, deq_ptr_d;
  logic [CW-1:0] count_q, count_d, pend_q, pend_d, drop_q, drop_d, wrong_path;
  logic [DEPTH-1:0] dv_q, dv_d;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] pc_d [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [31:0] data_d [DEPTH];
  logic alloc, drop, fill, deq;
  assign fetch_rdy    = ({1'b0, count_q} + {1'b0, drop_q}) < (CW+1)'(DEPTH);
  assign inst_val_Fhl = (count_q != '0) && dv_q[deq_ptr_q];
  assign inst_Fhl     = data_q[deq_ptr_q];
  assign pc_Fhl       = pc_q[deq_ptr_q];
  assign alloc = imemreq_fire && fetch_rdy;
  assign drop  = imemresp_val && (drop_q != '0);
  assign fill  = imemresp_val && (drop_q == '0) && (pend_q != '0);
  assign deq   = inst_val_Fhl && inst_rdy_Fhl;
  // Every fetch still in flight at a redirect returns later and must be dropped
  assign wrong_path = drop_q + pend_q;
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    deq_ptr_d   = deq_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    drop_d      = drop_q;
    dv_d        = dv_q;
    pc_d        = pc_q;
    data_d      = data_q;
    if (squash) begin
      dv_d        = '0;
      fill_ptr_d  = '0;
      deq_ptr_d   = '0;
      alloc_ptr_d = alloc ? PW'(1) : '0;
      count_d     = alloc ? CW'(1) : '0;
      pend_d      = alloc ? CW'(1) : '0;
      drop_d      = (imemresp_val && wrong_path != '0) ? wrong_path - CW'(1) : wrong_path;
      if (alloc) pc_d[0] = imemreq_pc;
    end else begin
      if (alloc) begin
        pc_d[alloc_ptr_q] = imemreq_pc;
        dv_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d       = alloc_ptr_q + PW'(1);
      end
      if (drop) drop_d = drop_q - CW'(1);
      if (fill) begin
        data_d[fill_ptr_q] = imemresp_msg_data;
        dv_d[fill_ptr_q]   = 1'b1;
        fill_ptr_d         = fill_ptr_q + PW'(1);
      end
      if (deq) begin
        dv_d[deq_ptr_q] = 1'b0;
        deq_ptr_d       = deq_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(alloc) - CW'(deq);
      pend_d  = pend_q + CW'(alloc) - CW'(fill);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      deq_ptr_q   <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      drop_q      <= '0;
      dv_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      deq_ptr_q   <= deq_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      dv_q        <= dv_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
    end
  end
endmodule

// File: tb/tb_riscv_core_fetch_queue.sv
// tb_riscv_core_fetch_queue: directed scenarios plus random traffic checked against a queue model
module tb_riscv_core_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic rst_n, fire, resp, sq, rdy;
  logic [31:0] req_pc, msg;
  logic fetch_rdy, inst_val;
  logic [31:0] inst, pc;
  int total = 0, bad = 0;
  typedef struct { logic [31:0] pc; logic [31:0] d; bit f; } ent_t;
  ent_t mq[$];
  int drop_m = 0;
  riscv_core_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .fetch_rdy(fetch_rdy), .imemreq_fire(fire), .imemreq_pc(req_pc),
    .imemresp_val(resp), .imemresp_msg_data(msg), .squash(sq), .inst_val_Fhl(inst_val),
    .inst_rdy_Fhl(rdy), .inst_Fhl(inst), .pc_Fhl(pc));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit m_rdy();
    return (mq.size() + drop_m) < DEPTH;
  endfunction
  function automatic bit m_val();
    return mq.size() != 0 && mq[0].f;
  endfunction
  task automatic step();
    bit r = m_rdy();
    bit v = m_val();
    int pend = 0;
    bit done = 0;
    foreach (mq[i]) if (!mq[i].f) pend++;
    if (sq) begin
      int s = drop_m + pend;
      if (resp && s > 0) s--;
      drop_m = s;
      mq.delete();
      if (fire && r) mq.push_back('{req_pc, 32'h0, 1'b0});
    end else begin
      if (resp) begin
        if (drop_m > 0) drop_m--;
        else foreach (mq[i]) if (!done && !mq[i].f) begin mq[i].d = msg; mq[i].f = 1; done = 1; end
      end
      if (v && rdy) void'(mq.pop_front());
      if (fire && r) mq.push_back('{req_pc, 32'h0, 1'b0});
    end
  endtask
  always @(posedge clk) if (rst_n) step();
  always @(negedge clk) if (rst_n) begin
    chk("fetch_rdy", {31'b0, fetch_rdy}, {31'b0, m_rdy()});
    chk("inst_val", {31'b0, inst_val}, {31'b0, m_val()});
    if (m_val()) begin
      chk("pc_Fhl", pc, mq[0].pc);
      chk("inst_Fhl", inst, mq[0].d);
    end
  end
  task automatic drive(input bit f, input logic [31:0] p, input bit rv, input logic [31:0] d,
                       input bit s, input bit r);
    fire = f; req_pc = p; resp = rv; msg = d; sq = s; rdy = r;
    @(negedge clk);
  endtask
  task automatic head(input string nm, input bit v, input logic [31:0] p, input logic [31:0] d);
    chk({nm, " val"}, {31'b0, inst_val}, {31'b0, v});
    if (v) begin
      chk({nm, " pc"}, pc, p);
      chk({nm, " inst"}, inst, d);
    end
  endtask
  initial begin
    rst_n = 0; fire = 0; resp = 0; sq = 0; rdy = 0; req_pc = 0; msg = 0;
    #12;
    chk("reset val", {31'b0, inst_val}, 32'h0);
    chk("reset fetch_rdy", {31'b0, fetch_rdy}, 32'h1);
    chk("reset inst", inst, 32'h0);
    chk("reset pc", pc, 32'h0);
    @(negedge clk); rst_n = 1;
    // sequential fetch
    drive(1, 32'h80000, 0, 0, 0, 1);
    drive(1, 32'h80004, 1, 32'hA, 0, 1); head("seq0", 1, 32'h80000, 32'hA);
    drive(1, 32'h80008, 1, 32'hB, 0, 1); head("seq1", 1, 32'h80004, 32'hB);
    drive(0, 0, 1, 32'hC, 0, 1);         head("seq2", 1, 32'h80008, 32'hC);
    drive(0, 0, 0, 0, 0, 1);             head("seq end", 0, 0, 0);
    // full queue, ignored fire, stall hold, drain
    drive(1, 32'h80000, 0, 0, 0, 0);
    drive(1, 32'h80004, 1, 32'hA, 0, 0);
    drive(1, 32'h80008, 1, 32'hB, 0, 0);
    drive(1, 32'h8000C, 1, 32'hC, 0, 0);
    drive(0, 0, 1, 32'hD, 0, 0);
    chk("full fetch_rdy", {31'b0, fetch_rdy}, 32'h0);
    drive(1, 32'h9999, 0, 0, 0, 0);
    chk("full ignore fetch_rdy", {31'b0, fetch_rdy}, 32'h0);
    head("full head", 1, 32'h80000, 32'hA);
    drive(0, 0, 0, 0, 0, 1);
    chk("rdy after deq", {31'b0, fetch_rdy}, 32'h1);
    head("deq1", 1, 32'h80004, 32'hB);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      head("stall", 1, 32'h80004, 32'hB);
    end
    drive(0, 0, 0, 0, 0, 1); head("drain1", 1, 32'h80008, 32'hC);
    drive(0, 0, 0, 0, 0, 1); head("drain2", 1, 32'h8000C, 32'hD);
    drive(0, 0, 0, 0, 0, 1); head("drain end", 0, 0, 0);
    // redirect with two pending fetches
    drive(1, 32'h80200, 0, 0, 0, 1);
    drive(1, 32'h80204, 0, 0, 0, 1);
    drive(1, 32'h80100, 0, 0, 1, 1); head("sq", 0, 0, 0);
    drive(0, 0, 1, 32'h11, 0, 1);    head("drop1", 0, 0, 0);
    drive(0, 0, 1, 32'h22, 0, 1);    head("drop2", 0, 0, 0);
    drive(0, 0, 1, 32'hD, 0, 0);     head("new path", 1, 32'h80100, 32'hD);
    drive(0, 0, 0, 0, 0, 1);         head("new path end", 0, 0, 0);
    // squash with same-cycle response and dequeue handshake
    drive(1, 32'h80300, 0, 0, 0, 0);
    drive(1, 32'h80304, 1, 32'h31, 0, 0); head("pre sim", 1, 32'h80300, 32'h31);
    drive(0, 0, 1, 32'h77, 1, 1);         head("sim sq", 0, 0, 0);
    chk("sim fetch_rdy", {31'b0, fetch_rdy}, 32'h1);
    drive(1, 32'h80400, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h44, 0, 0);         head("sim no drop", 1, 32'h80400, 32'h44);
    drive(0, 0, 0, 0, 0, 1);
    // async reset mid-operation
    drive(1, 32'h80500, 0, 0, 0, 0);
    drive(1, 32'h80504, 1, 32'hE1, 0, 0);
    drive(1, 32'h80508, 1, 32'hE2, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk); #2;
    rst_n = 0; mq.delete(); drop_m = 0;
    #1;
    chk("async val", {31'b0, inst_val}, 32'h0);
    chk("async fetch_rdy", {31'b0, fetch_rdy}, 32'h1);
    @(negedge clk); rst_n = 1;
    drive(0, 0, 1, 32'h66, 0, 1); head("stray", 0, 0, 0);
    chk("stray fetch_rdy", {31'b0, fetch_rdy}, 32'h1);
    // random traffic
    for (int i = 0; i < 3000; i++)
      drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    drive(0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
